// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request/result bundle between requesters, the arbiter and the shared divider.
interface div_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [WIDTH*N_REQ-1:0] req_dividend;
    logic [WIDTH*N_REQ-1:0] req_divisor;
    logic [N_REQ-1:0]       res_valid;
    logic [WIDTH-1:0]       res_quotient;
    logic [WIDTH-1:0]       res_remainder;
    logic                   res_error;
    logic [WIDTH-1:0]       div_dividend;
    logic [WIDTH-1:0]       div_divisor;
    logic                   div_in_valid;
    logic [WIDTH-1:0]       div_quotient;
    logic [WIDTH-1:0]       div_remainder;
    logic                   div_out_valid;
    logic                   div_busy;

    modport slave (
        input  req_valid, req_dividend, req_divisor, div_quotient, div_remainder, div_out_valid, div_busy,
        output res_valid, res_quotient, res_remainder, res_error, div_dividend, div_divisor, div_in_valid
    );
    modport master (
        output req_valid, req_dividend, req_divisor, div_quotient, div_remainder, div_out_valid, div_busy,
        input  res_valid, res_quotient, res_remainder, res_error, div_dividend, div_divisor, div_in_valid
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider among N_REQ requesters,
// with local divide-by-zero answers and a watchdog for a hung divider.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst_n,
    div_arbiter_if.slave arb_if
);
    localparam int RW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q;
    logic [N_REQ-1:0] pending_q, pending_d, res_valid_q;
    logic [WIDTH-1:0] dividend_q [N_REQ];
    logic [WIDTH-1:0] divisor_q  [N_REQ];
    logic [WIDTH-1:0] req_dd     [N_REQ];
    logic [WIDTH-1:0] req_ds     [N_REQ];
    logic [WIDTH-1:0] fwd_dd, fwd_ds, res_quotient_q, res_remainder_q, div_dividend_q, div_divisor_q;
    logic [RW-1:0]    rr_q, grant_q, g_c, rr_g, rr_w;
    logic [RW:0]      idx_c;
    logic [CW-1:0]    wdog_q;
    logic             found_c, grant_c, res_error_q, div_in_valid_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_dd[i] = arb_if.req_dividend[i*WIDTH +: WIDTH];
        assign req_ds[i] = arb_if.req_divisor[i*WIDTH +: WIDTH];
    end

    // Scan downwards so the nearest pending requester at or after rr wins.
    always_comb begin
        g_c     = '0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_c = {1'b0, rr_q} + (RW+1)'(k);
            if (idx_c >= (RW+1)'(N_REQ)) idx_c = idx_c - (RW+1)'(N_REQ);
            if (pending_q[idx_c[RW-1:0]]) begin
                g_c     = idx_c[RW-1:0];
                found_c = 1'b1;
            end
        end
    end

    // A strobe landing in the grant cycle is forwarded so the newest operands are used.
    assign fwd_dd  = arb_if.req_valid[g_c] ? req_dd[g_c] : dividend_q[g_c];
    assign fwd_ds  = arb_if.req_valid[g_c] ? req_ds[g_c] : divisor_q[g_c];
    assign grant_c = (state_q == IDLE) && found_c && !arb_if.div_busy;
    assign rr_g    = (g_c == RW'(N_REQ - 1)) ? '0 : g_c + 1'b1;
    assign rr_w    = (grant_q == RW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        pending_d = pending_q | arb_if.req_valid;
        if (grant_c && fwd_ds == '0) pending_d[g_c] = 1'b0;
        if (state_q == ISSUE && !arb_if.req_valid[grant_q]) pending_d[grant_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pending_q       <= '0;
            rr_q            <= '0;
            grant_q         <= '0;
            wdog_q          <= '0;
            res_valid_q     <= '0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_error_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            div_in_valid_q  <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                dividend_q[k] <= '0;
                divisor_q[k]  <= '0;
            end
        end else begin
            pending_q      <= pending_d;
            res_valid_q    <= '0;
            div_in_valid_q <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                if (arb_if.req_valid[k]) begin
                    dividend_q[k] <= req_dd[k];
                    divisor_q[k]  <= req_ds[k];
                end
            end
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        grant_q <= g_c;
                        if (fwd_ds == '0) begin
                            res_valid_q     <= N_REQ'(1) << g_c;
                            res_quotient_q  <= '1;
                            res_remainder_q <= fwd_dd;
                            res_error_q     <= 1'b1;
                            rr_q            <= rr_g;
                        end else begin
                            div_dividend_q <= fwd_dd;
                            div_divisor_q  <= fwd_ds;
                            div_in_valid_q <= 1'b1;
                            state_q        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (arb_if.div_out_valid) begin
                        res_valid_q     <= N_REQ'(1) << grant_q;
                        res_quotient_q  <= arb_if.div_quotient;
                        res_remainder_q <= arb_if.div_remainder;
                        res_error_q     <= 1'b0;
                        rr_q            <= rr_w;
                        state_q         <= IDLE;
                    end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                        res_valid_q     <= N_REQ'(1) << grant_q;
                        res_quotient_q  <= '0;
                        res_remainder_q <= '0;
                        res_error_q     <= 1'b1;
                        rr_q            <= rr_w;
                        state_q         <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_if.res_valid     = res_valid_q;
    assign arb_if.res_quotient  = res_quotient_q;
    assign arb_if.res_remainder = res_remainder_q;
    assign arb_if.res_error     = res_error_q;
    assign arb_if.div_dividend  = div_dividend_q;
    assign arb_if.div_divisor   = div_divisor_q;
    assign arb_if.div_in_valid  = div_in_valid_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter with a behavioural divider stub.
module tb_div_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    div_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
    div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .arb_if(bus));

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic err;} exp_t;
    typedef struct {int idx; logic [W-1:0] dd; logic [W-1:0] ds; logic [W-1:0] q; logic [W-1:0] r; logic err;} vec_t;

    exp_t       exp_q [N][$];
    exp_t       sticky [N];
    logic [N-1:0] repeat_ok = '0;
    int         order [$];
    int         checks = 0, errors = 0, div_cnt = 0, res_cnt = 0;
    int         lat = 3, cnt = 0;
    logic       hang = 1'b0, inject = 1'b0;
    logic [W-1:0] a_m, b_m;
    vec_t       vecs [7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int i, input logic [W-1:0] q, input logic [W-1:0] r, input logic err);
        exp_t e;
        e.q = q; e.r = r; e.err = err;
        exp_q[i].push_back(e);
    endtask

    task automatic strobe(input int i, input logic [W-1:0] dd, input logic [W-1:0] ds);
        bus.req_valid[i] = 1'b1;
        bus.req_dividend[i*W +: W] = dd;
        bus.req_divisor[i*W +: W] = ds;
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        int left = 1;
        while (left != 0 && n < 600) begin
            left = 0;
            for (int k = 0; k < N; k++) left += exp_q[k].size();
            if (left != 0) begin
                @(negedge clk);
                n++;
            end
        end
        chk({name, "_drained"}, left, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (bus.div_in_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_issue_seen"}, bus.div_in_valid, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        cnt = 0; hang = 1'b0; inject = 1'b0;
        bus.div_busy = 1'b0; bus.div_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) exp_q[k].delete();
        repeat_ok = '0;
        order.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_res_valid"}, bus.res_valid, 0);
        chk({name, "_res_q"}, bus.res_quotient, 0);
        chk({name, "_res_r"}, bus.res_remainder, 0);
        chk({name, "_res_err"}, bus.res_error, 0);
        chk({name, "_div_in_valid"}, bus.div_in_valid, 0);
        chk({name, "_div_dd"}, bus.div_dividend, 0);
        chk({name, "_div_ds"}, bus.div_divisor, 0);
    endtask

    // Divider stub: fixed latency, optional hang (never answers), optional injected stray strobe.
    initial forever begin
        @(negedge clk);
        bus.div_out_valid = inject;
        inject = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                bus.div_busy = 1'b0;
                if (!hang) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_quotient  = (b_m == 0) ? '1 : a_m / b_m;
                    bus.div_remainder = (b_m == 0) ? a_m : a_m % b_m;
                end
            end
        end
        if (bus.div_in_valid === 1'b1) begin
            a_m = bus.div_dividend;
            b_m = bus.div_divisor;
            cnt = lat;
            bus.div_busy = 1'b1;
        end
    end

    // Result monitor: pops the per-requester scoreboard on every strobe.
    initial begin
        exp_t e;
        int i;
        forever begin
            @(negedge clk);
            if (bus.div_in_valid === 1'b1) div_cnt++;
            if (bus.res_valid !== '0) begin
                res_cnt++;
                i = 0;
                for (int k = 0; k < N; k++) if (bus.res_valid[k]) i = k;
                chk("res_onehot", $countones(bus.res_valid), 1);
                if (exp_q[i].size() > 0 || repeat_ok[i]) begin
                    e = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : sticky[i];
                    order.push_back(i);
                    chk($sformatf("res_q[%0d]", i), bus.res_quotient, e.q);
                    chk($sformatf("res_r[%0d]", i), bus.res_remainder, e.r);
                    chk($sformatf("res_err[%0d]", i), bus.res_error, e.err);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res: res_valid=%b with nothing expected", bus.res_valid);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, r0, n, s, p;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 1};
        vecs[0] = '{0, 32'hFFF,      32'd4,  32'h3FF,      32'd3,   1'b0};
        vecs[1] = '{2, 32'h55,       32'd0,  32'hFFFFFFFF, 32'h55,  1'b1};
        vecs[2] = '{1, 32'd100,      32'd7,  32'd14,       32'd2,   1'b0};
        vecs[3] = '{3, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF,   1'b0};
        vecs[4] = '{0, 32'd5,        32'd9,  32'd0,        32'd5,   1'b0};
        vecs[5] = '{1, 32'd0,        32'd0,  32'hFFFFFFFF, 32'd0,   1'b1};
        vecs[6] = '{3, 32'd1000,     32'd1,  32'd1000,     32'd0,   1'b0};
        bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0;
        bus.div_quotient = '0; bus.div_remainder = '0;
        bus.div_out_valid = 1'b0; bus.div_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request with issue latency
        c0 = div_cnt;
        push_exp(0, 32'h3FF, 32'd3, 1'b0);
        strobe(0, 32'hFFF, 32'd4);
        chk("t1_not_yet_issued", bus.div_in_valid, 0);
        @(negedge clk);
        chk("t1_issue_latency", bus.div_in_valid, 1);
        drain("t1");
        chk("t1_issue_count", div_cnt - c0, 1);

        // Divide by zero answered locally, 2 cycles after the strobe
        c0 = div_cnt;
        push_exp(2, 32'hFFFFFFFF, 32'h55, 1'b1);
        strobe(2, 32'h55, 32'd0);
        chk("t3_res_early", bus.res_valid, 0);
        @(negedge clk);
        chk("t3_res_latency", bus.res_valid, 4'b0100);
        drain("t3");
        chk("t3_no_issue", div_cnt - c0, 0);

        for (int v = 0; v < 7; v++) begin
            push_exp(vecs[v].idx, vecs[v].q, vecs[v].r, vecs[v].err);
            strobe(vecs[v].idx, vecs[v].dd, vecs[v].ds);
            drain($sformatf("vec%0d", v));
        end

        // All four strobe together from rr=0; requester 1 re-strobes during its own WAIT
        do_reset();
        push_exp(0, 32'd333, 32'd1, 1'b0);
        push_exp(1, 32'd285, 32'd5, 1'b0);
        push_exp(2, 32'd272, 32'd8, 1'b0);
        push_exp(3, 32'd307, 32'd9, 1'b0);
        bus.req_dividend = {32'd4000, 32'd3000, 32'd2000, 32'd1000};
        bus.req_divisor  = {32'd13, 32'd11, 32'd7, 32'd3};
        bus.req_valid = 4'hF;
        @(negedge clk);
        bus.req_valid = '0;
        wait_issue("t2_first");
        @(negedge clk);
        wait_issue("t2_second");
        @(negedge clk);
        push_exp(1, 32'd83, 32'd2, 1'b0);
        strobe(1, 32'd500, 32'd6);
        drain("t2");
        chk("t2_result_count", order.size(), 5);
        for (int k = 0; k < 5 && k < order.size(); k++) chk($sformatf("t2_order%0d", k), order[k], exp_order[k]);

        // Hung divider: watchdog abort, stray late strobe ignored, then normal service
        hang = 1'b1;
        r0 = res_cnt;
        push_exp(1, 32'd0, 32'd0, 1'b1);
        strobe(1, 32'd200, 32'd3);
        wait_issue("t4");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.res_valid === '0 && n < 200);
        chk("t4_timeout_cycles", n, TO + 1);
        hang = 1'b0;
        repeat (2) @(negedge clk);
        inject = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_late_ignored", res_cnt - r0, 1);
        push_exp(1, 32'd66, 32'd2, 1'b0);
        strobe(1, 32'd200, 32'd3);
        drain("t4_after");

        // Async reset in WAIT aborts the operation and drops pending work
        lat = 20;
        r0 = res_cnt;
        strobe(2, 32'd50, 32'd5);
        wait_issue("t5");
        repeat (3) @(negedge clk);
        strobe(0, 32'd9, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_result", res_cnt - r0, 0);
        lat = 3;

        // Fairness: requester 3 strobes every cycle, requester 0 once
        do_reset();
        sticky[3] = '{32'd10, 32'd0, 1'b0};
        repeat_ok[3] = 1'b1;
        s = 0;
        for (int c = 0; c < 40; c++) begin
            bus.req_dividend[3*W +: W] = 32'd90;
            bus.req_divisor[3*W +: W] = 32'd9;
            bus.req_valid = 4'b1000;
            if (c == 6) begin
                #1;
                s = order.size();
                bus.req_dividend[0 +: W] = 32'd77;
                bus.req_divisor[0 +: W] = 32'd7;
                bus.req_valid[0] = 1'b1;
                push_exp(0, 32'd11, 32'd0, 1'b0);
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        drain("t6");
        repeat (20) @(negedge clk);
        repeat_ok = '0;
        p = -1;
        for (int k = order.size() - 1; k >= s; k--) if (order[k] == 0) p = k;
        chk("t6_req0_served", p >= s, 1);
        chk("t6_within_two_grants", (p >= s) && (p - s <= 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
